// File: rtl/control_unit_if.sv
// control_unit_if: bundles the controller's handshake and control-line signals.
//   start       : level request to leave IDLE
//   IR_out      : opcode currently held in IR
//   ACC_sign    : ACC[15], 1 = negative
//   C_out       : control lines, bit k = Ck
//   state_out   : current FSM state encoding (debug)
//   halted      : high while in HALT
//   instr_done  : one-cycle pulse in an instruction's final state
//   instr_count : saturating count of completed instructions
// Modport master is the controller side; slave is the datapath/stimulus side.
interface control_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [7:0]           IR_out;
  logic                 ACC_sign;
  logic [15:0]          C_out;
  logic [3:0]           state_out;
  logic                 halted;
  logic                 instr_done;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    input  start, IR_out, ACC_sign,
    output C_out, state_out, halted, instr_done, instr_count
  );

  modport slave (
    output start, IR_out, ACC_sign,
    input  C_out, state_out, halted, instr_done, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute controller for the 8-bit-address,
// 16-bit-word accumulator datapath.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : control_unit_if.master (start, IR_out, ACC_sign in;
//           C_out, state_out, halted, instr_done, instr_count out)
module control_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  control_unit_if.master    bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_E1   = 4'd5,
    S_E2   = 4'd6,
    S_E3   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_JMPGEZ, OP_JMP
  } op_t;

  state_t               state_reg;
  op_t                  op_reg;
  logic                 halt_entry_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  op_t        dec_op;
  logic       dec_halt;
  logic [15:0] c_next;
  logic       done_next;

  // Opcode classification; HALT is kept apart from the execute-class ops.
  always_comb begin
    dec_halt = (bus.IR_out == 8'h07);
    case (bus.IR_out)
      8'h01:   dec_op = OP_STORE;
      8'h02:   dec_op = OP_LOAD;
      8'h03:   dec_op = OP_ADD;
      8'h04:   dec_op = OP_SUB;
      8'h08:   dec_op = OP_AND;
      8'h05:   dec_op = OP_JMPGEZ;
      8'h06:   dec_op = OP_JMP;
      default: dec_op = OP_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      op_reg         <= OP_NOP;
      halt_entry_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      halt_entry_reg <= 1'b0;
      if (done_next && (count_reg != {CNT_WIDTH{1'b1}}))
        count_reg <= count_reg + 1'b1;
      case (state_reg)
        S_IDLE: if (bus.start) state_reg <= S_F0;
        S_F0:   state_reg <= S_F1;
        S_F1:   state_reg <= S_F2;
        S_F2:   state_reg <= S_DEC;
        S_DEC: begin
          op_reg <= dec_op;
          if (dec_halt) begin
            state_reg      <= S_HALT;
            halt_entry_reg <= 1'b1;
          end else if (dec_op == OP_NOP) begin
            state_reg <= S_F0;
          end else begin
            state_reg <= S_E1;
          end
        end
        S_E1:   state_reg <= (op_reg == OP_JMP || op_reg == OP_JMPGEZ) ? S_F0 : S_E2;
        S_E2:   state_reg <= (op_reg == OP_STORE) ? S_F0 : S_E3;
        S_E3:   state_reg <= S_F0;
        S_HALT: state_reg <= S_HALT;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the registered state; ACC_sign matters only in E1.
  // C6 appears only in F1 and C14 only in E1, so they never coincide.
  always_comb begin
    c_next    = 16'h0000;
    done_next = 1'b0;
    case (state_reg)
      S_F0: c_next[0] = 1'b1;
      S_F1: begin
        c_next[1] = 1'b1;
        c_next[6] = 1'b1;
      end
      S_F2: begin
        c_next[2] = 1'b1;
        c_next[3] = 1'b1;
      end
      S_DEC: done_next = (dec_op == OP_NOP) && !dec_halt;
      S_E1: begin
        case (op_reg)
          OP_STORE:  c_next[5]  = 1'b1;
          OP_JMPGEZ: c_next[14] = !bus.ACC_sign;
          OP_JMP:    c_next[14] = 1'b1;
          default:   c_next[1]  = 1'b1;
        endcase
        done_next = (op_reg == OP_JMP) || (op_reg == OP_JMPGEZ);
      end
      S_E2: begin
        if (op_reg == OP_STORE) c_next[4] = 1'b1;
        else                    c_next[7] = 1'b1;
        done_next = (op_reg == OP_STORE);
      end
      S_E3: begin
        case (op_reg)
          OP_ADD:  c_next[9]  = 1'b1;
          OP_SUB:  c_next[10] = 1'b1;
          OP_AND:  c_next[12] = 1'b1;
          default: c_next[11] = 1'b1;
        endcase
        done_next = 1'b1;
      end
      // Count the HALT instruction once, in its first HALT cycle.
      S_HALT: done_next = halt_entry_reg;
      default: ;
    endcase
  end

  assign bus.C_out       = c_next;
  assign bus.state_out   = state_reg;
  assign bus.halted      = (state_reg == S_HALT);
  assign bus.instr_done  = done_next;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_count;

  control_unit_if #(.CNT_WIDTH(16)) bus ();

  control_unit #(.CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from F0 back to F0; len is cycles from F0 to next F0.
  task automatic exec(input string name, input logic [7:0] op, input logic sign,
                      input int len, input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2);
    logic [15:0] ev [3];
    int n;
    ev = '{e0, e1, e2};
    n = len - 4;
    chk({name, " F0 state"}, 32'(bus.state_out), 32'd1);
    chk({name, " F0 C"}, 32'(bus.C_out), 32'h0001);
    step();
    chk({name, " F1 C"}, 32'(bus.C_out), 32'h0042);
    step();
    chk({name, " F2 C"}, 32'(bus.C_out), 32'h000C);
    bus.IR_out   = op;
    bus.ACC_sign = sign;
    step();
    chk({name, " DEC state"}, 32'(bus.state_out), 32'd4);
    chk({name, " DEC C"}, 32'(bus.C_out), 32'h0000);
    chk({name, " DEC done"}, 32'(bus.instr_done), 32'(n == 0));
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s E%0d C", name, i + 1), 32'(bus.C_out), 32'(ev[i]));
      chk($sformatf("%s E%0d done", name, i + 1), 32'(bus.instr_done), 32'(i == n - 1));
    end
    step();
    chk({name, " next F0"}, 32'(bus.state_out), 32'd1);
    exp_count++;
    chk({name, " count"}, 32'(bus.instr_count), 32'(exp_count));
    $display("instr %s op=%02h sign=%0d len=%0d count=%0d", name, op, sign, len, bus.instr_count);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.IR_out = 8'h00;
    bus.ACC_sign = 1'b0;
    step();
    step();
    chk("rst state", 32'(bus.state_out), 32'd0);
    chk("rst C", 32'(bus.C_out), 32'h0000);
    chk("rst halted", 32'(bus.halted), 32'd0);
    chk("rst done", 32'(bus.instr_done), 32'd0);
    chk("rst count", 32'(bus.instr_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle state", 32'(bus.state_out), 32'd0);
      chk("idle C", 32'(bus.C_out), 32'h0000);
    end
    $display("idle 5 cycles state=%0d", bus.state_out);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;

    exec("LOAD",    8'h02, 1'b0, 7, 16'h0002, 16'h0080, 16'h0800);
    exec("JMPGEZ+", 8'h05, 1'b0, 5, 16'h4000, 16'h0000, 16'h0000);
    exec("JMPGEZ-", 8'h05, 1'b1, 5, 16'h0000, 16'h0000, 16'h0000);
    bus.start = 1'b1;  // ignored outside IDLE
    exec("JMP",     8'h06, 1'b1, 5, 16'h4000, 16'h0000, 16'h0000);
    bus.start = 1'b0;
    exec("STORE",   8'h01, 1'b0, 6, 16'h0020, 16'h0010, 16'h0000);
    exec("ADD",     8'h03, 1'b0, 7, 16'h0002, 16'h0080, 16'h0200);
    exec("SUB",     8'h04, 1'b0, 7, 16'h0002, 16'h0080, 16'h0400);
    exec("AND",     8'h08, 1'b0, 7, 16'h0002, 16'h0080, 16'h1000);
    exec("NOP_FF",  8'hFF, 1'b0, 4, 16'h0000, 16'h0000, 16'h0000);
    exec("NOP_00",  8'h00, 1'b0, 4, 16'h0000, 16'h0000, 16'h0000);

    // HALT
    step();
    step();
    bus.IR_out = 8'h07;
    step();
    chk("HALT DEC done", 32'(bus.instr_done), 32'd0);
    step();
    chk("HALT state", 32'(bus.state_out), 32'd8);
    chk("HALT halted", 32'(bus.halted), 32'd1);
    chk("HALT entry done", 32'(bus.instr_done), 32'd1);
    exp_count++;
    for (int i = 0; i < 22; i++) begin
      bus.start = i[0];
      step();
      chk("HALT stay halted", 32'(bus.halted), 32'd1);
      chk("HALT C", 32'(bus.C_out), 32'h0000);
      chk("HALT done", 32'(bus.instr_done), 32'd0);
      chk("HALT count", 32'(bus.instr_count), 32'(exp_count));
    end
    $display("halt held 22 cycles count=%0d", bus.instr_count);
    bus.start = 1'b0;

    // Reset out of HALT, then reset asynchronously mid-E2 of ADD
    rst_n = 1'b0;
    #1;
    chk("rst2 state", 32'(bus.state_out), 32'd0);
    chk("rst2 halted", 32'(bus.halted), 32'd0);
    chk("rst2 count", 32'(bus.instr_count), 32'd0);
    step();
    rst_n = 1'b1;
    exp_count = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exec("NOP_pre", 8'h00, 1'b0, 4, 16'h0000, 16'h0000, 16'h0000);
    step();
    step();
    bus.IR_out = 8'h03;
    step();
    step();
    step();
    chk("ADD E2 state", 32'(bus.state_out), 32'd6);
    chk("ADD E2 C", 32'(bus.C_out), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst state", 32'(bus.state_out), 32'd0);
    chk("async rst C", 32'(bus.C_out), 32'h0000);
    chk("async rst count", 32'(bus.instr_count), 32'd0);
    chk("async rst done", 32'(bus.instr_done), 32'd0);
    $display("async reset mid-E2 state=%0d count=%0d", bus.state_out, bus.instr_count);
    step();
    rst_n = 1'b1;
    step();
    chk("post rst idle", 32'(bus.state_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired fetch/decode/execute controller for the 8-bit-address, 16-bit-word accumulator datapath.
- Drives the Cn control lines consumed by PC, MAR, MBR, IR, BR and ACC.
- Asserts C6 (PC increment) during fetch and C14 (PC load from MBR[7:0]) on taken jumps.
- Also reports halt status and a completed-instruction count.

Parameters:
- CNT_WIDTH, 16, width of instr_count (saturating).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE when high.
- IR_out  in  8  opcode currently held in IR.
- ACC_sign  in  1  ACC[15]; 1 = negative.
- C_out  out  16  control lines; bit k = Ck.
- state_out  out  4  current state encoding, for debug.
- halted  out  1  high while in HALT.
- instr_done  out  1  one-cycle pulse on the cycle an instruction's last state is active.
- instr_count  out  CNT_WIDTH  number of completed instructions.

Behaviour:
- Clocking and reset
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset forces state IDLE immediately, mid-instruction included. Reset values: C_out=0, halted=0, instr_done=0, instr_count=0, state_out=0.
- Control-line meaning
  - C0 MAR<=PC; C1 MBR<=mem[MAR]; C2 IR<=MBR[15:8]; C3 MAR<=MBR[7:0].
  - C4 mem[MAR]<=MBR; C5 MBR<=ACC; C6 PC<=PC+1; C7 BR<=MBR.
  - C8 ACC<=0; C9 ACC<=ACC+BR; C10 ACC<=ACC-BR; C11 ACC<=BR.
  - C12 ACC<=ACC&BR; C13 unused, always 0; C14 PC<=MBR[7:0]; C15 unused, always 0.
- Output timing
  - C_out is a Moore decode of the registered state (plus ACC_sign in E1 only).
  - The selected register updates at the rising edge that ends the state.
- State encodings
  - IDLE=0, F0=1, F1=2, F2=3, DEC=4, E1=5, E2=6, E3=7, HALT=8.
- State sequence and outputs
  - IDLE: C_out=0. Go to F0 when start=1, else stay.
  - F0: C0.
  - F1: C1|C6.
  - F2: C2|C3.
  - DEC: C_out=0. Branch on IR_out (valid from this cycle).
- Opcodes (branch taken from DEC)
  - 0x01 STORE: E1 C5, E2 C4, then F0.
  - 0x02 LOAD: E1 C1, E2 C7, E3 C11, then F0.
  - 0x03 ADD: as LOAD, but E3 C9.
  - 0x04 SUB: as LOAD, but E3 C10.
  - 0x08 AND: as LOAD, but E3 C12.
  - 0x05 JMPGEZ: E1 drives C14 if ACC_sign=0, else 0. Then F0.
  - 0x06 JMP: E1 C14, then F0.
  - 0x07 HALT: go to HALT.
  - Any other value (incl. 0x00) is NOP: DEC goes directly to F0.
- Latency, start-of-F0 to next F0:
  - NOP 4 cycles; JMP/JMPGEZ 5; STORE 6; LOAD/ADD/SUB/AND 7.
- Jumps
  - MBR still holds the instruction word in E1, so C14 loads the operand address.
  - C6 and C14 are never asserted in the same cycle.
- instr_done
  - Pulses for exactly one cycle in the final state of each instruction: DEC for NOP, E1 for jumps, E2 for STORE, E3 for ALU/LOAD ops, and on entry to HALT.
  - instr_count increments on that same edge and saturates at all-ones.
- HALT
  - C_out=0, halted=1. Stays in HALT regardless of start; only rst_n exits.
- start is sampled only in IDLE. After leaving IDLE the FSM runs continuously.

Test Plan:
- Reset then start=0 for 5 cycles -> state_out=0, C_out=0x0000 throughout. Pulse start -> next cycles C_out=0x0001, 0x0042, 0x000C, 0x0000.
- IR_out=0x02 (LOAD) -> E1..E3 C_out = 0x0002, 0x0080, 0x0800; instr_done high only in E3; instr_count 0->1; next state F0.
- IR_out=0x05 with ACC_sign=0 -> E1 C_out=0x4000. Repeat with ACC_sign=1 -> E1 C_out=0x0000. Both take 5 cycles.
- IR_out=0x01 (STORE) -> E1 0x0020, E2 0x0010, 6-cycle instruction. IR_out=0xFF -> DEC to F0 with no E states.
- IR_out=0x07 -> halted=1, C_out=0 for 20+ cycles with start toggling; instr_count stops changing.
- Assert rst_n=0 mid-E2 of ADD -> C_out=0 and state_out=0 before the next clock edge; instr_count=0.
